img_stream_proc: RTL
====================

// Module: img_stream_proc
// PURPOSE
//  Streaming RGB888 image processor: accepts NPIX pixels/beat over valid/ready, applies a runtime-selected
//  point operation (pass, brightness add/sub, invert-gray, threshold) and emits a framed stream with VSYNC/HSYNC.
//  Sits between the frame source (memory reader / camera) and the image writer; replaces compile-time op selection.
// PARAMETERS
//  WIDTH           500  pixels per line; must be a multiple of NPIX
//  HEIGHT          500  lines per frame
//  NPIX            2    pixels per beat (1,2,4)
//  DW              8    bits per colour component
//  START_UP_DELAY  100  cycles in VSYNC state before first line
//  HSYNC_DELAY     160  idle cycles between lines
// PORTS
//  HCLK        in   1             clock, rising edge
//  HRESET      in   1             asynchronous, active-high reset
//  start       in   1             frame start pulse; ignored unless idle
//  cfg_mode    in   3             0 pass, 1 bright-add, 2 bright-sub, 3 invert, 4 threshold; 5-7 = pass
//  cfg_value   in   DW            brightness offset
//  cfg_thresh  in   DW            threshold level
//  in_valid    in   1             upstream beat valid
//  in_ready    out  1             block accepts beat
//  in_data     in   NPIX*3*DW     pixel k at [k*3*DW +: 3*DW], order {R,G,B}, R in MSBs
//  out_valid   out  1             output beat valid
//  out_ready   in   1             downstream accepts beat
//  out_data    out  NPIX*3*DW     processed pixels, same packing
//  VSYNC       out  1             high while in VSYNC state
//  HSYNC       out  1             equals out_valid
//  out_eol     out  1             qualifies last beat of a line
//  ctrl_done   out  1             one-cycle pulse after last beat of frame leaves the block
// BEHAVIOUR
//  - Reset: FSM IDLE, all counters 0, in_ready/out_valid/VSYNC/HSYNC/out_eol/ctrl_done 0, out_data 0.
//  - FSM IDLE->VSYNC on start (cfg_* latched that cycle); VSYNC->HSYNC after START_UP_DELAY cycles;
//    HSYNC->DATA after HSYNC_DELAY cycles; DATA->HSYNC on acceptance of beat col==WIDTH-NPIX when row<HEIGHT-1;
//    DATA->DRAIN on that beat when row==HEIGHT-1; DRAIN->IDLE once output register empties, ctrl_done pulses then.
//  - in_ready = (state==DATA) & (~out_valid | out_ready). Beat accepted when in_valid&in_ready.
//  - Latency 1 cycle: accepted beat appears in out_data/out_valid next cycle; held stable while out_valid&~out_ready.
//  - col advances by NPIX per accepted beat, wraps to 0 at line end, row +1; no counter advances without handshake.
//  - Arithmetic per component, width DW+2 internally, MAX=2^DW-1:
//    add: min(c+value,MAX); sub: max(c-value,0); invert: g=(R+G+B)/3 (floor), R=G=B=MAX-g;
//    threshold: g>cfg_thresh -> R=G=B=MAX else 0 (strictly greater).
//  - cfg_* changes mid-frame have no effect until the next start.
//  - start while not IDLE ignored. HRESET mid-frame aborts immediately; no ctrl_done issued.
//  - out_eol=1 with the beat holding col WIDTH-NPIX; ctrl_done never coincides with out_valid.
// CONFIGURATION
//  IMG_PROC_SAT_CNT_EN defined: extra port sat_count out 32 = number of components clipped (add/sub only)
//    in the last completed frame; internal counter clears on start, copied to sat_count on ctrl_done; reset 0.
//  Undefined: port absent, no counter logic; all other behaviour identical.
// STRUCTURE
//  img_proc_pkg: mode codes (MODE_PASS..MODE_THRESH), FSM state encodings (ST_IDLE,ST_VSYNC,ST_HSYNC,ST_DATA,
//    ST_DRAIN), saturating add/sub and avg3 functions.
//  Sub-module img_pix_op: combinational one-pixel operator (mode,value,thresh,RGB -> RGB[,sat flags]),
//    instantiated NPIX times by generate; top holds FSM, counters, output register.
// TESTING (bench WIDTH=4, HEIGHT=2, NPIX=2, START_UP_DELAY=3, HSYNC_DELAY=2)
//  1 pass mode, out_ready=1, 4 beats streamed -> outputs equal inputs, 1-cycle latency, out_eol on beats 2,4,
//    ctrl_done single pulse after beat 4, VSYNC high exactly 3 cycles.
//  2 add value=100, pixel {200,100,0} -> {255,200,100}; sub value=100 same pixel -> {100,0,0}.
//  3 invert, pixel {30,60,91} -> g=60 -> {195,195,195}; threshold=90, pixels {90,90,90}->0, {91,91,91}->255.
//  4 out_ready low 5 cycles mid-line -> out_data stable, in_ready 0, no beat lost/duplicated, col unchanged.
//  5 HRESET asserted after 2 beats -> all outputs 0 next edge, no ctrl_done; new start runs full frame cleanly.
//  6 IMG_PROC_SAT_CNT_EN, add 100 on frame with 3 components >155 -> sat_count=3 after ctrl_done.

Source files
------------

// File: rtl/img_proc_pkg.sv
// img_proc_pkg: mode codes, FSM states and pixel arithmetic helpers
// shared by the image stream processor and its per-pixel operator.
package img_proc_pkg;

  localparam logic [2:0] MODE_PASS   = 3'd0;
  localparam logic [2:0] MODE_ADD    = 3'd1;
  localparam logic [2:0] MODE_SUB    = 3'd2;
  localparam logic [2:0] MODE_INV    = 3'd3;
  localparam logic [2:0] MODE_THRESH = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_VSYNC,
    ST_HSYNC,
    ST_DATA,
    ST_DRAIN
  } state_e;

  function automatic logic [31:0] sat_add(
    input logic [31:0] a,
    input logic [31:0] b,
    input logic [31:0] mx
  );
    logic [32:0] s;
    s = {1'b0, a} + {1'b0, b};
    return (s > {1'b0, mx}) ? mx : s[31:0];
  endfunction

  function automatic logic [31:0] sat_sub(
    input logic [31:0] a,
    input logic [31:0] b
  );
    return (b > a) ? 32'd0 : a - b;
  endfunction

  function automatic logic [31:0] avg3(
    input logic [31:0] a,
    input logic [31:0] b,
    input logic [31:0] c
  );
    return (a + b + c) / 32'd3;
  endfunction

endpackage

// File: rtl/img_pix_op.sv
// img_pix_op: combinational point operation on one RGB pixel.
// IMG_PROC_SAT_CNT_EN adds per-component clip flags for add/sub.
module img_pix_op
  import img_proc_pkg::*;
#(
  parameter int DW = 8
) (
  input  logic [2:0]      mode,
  input  logic [DW-1:0]   value,
  input  logic [DW-1:0]   thresh,
  input  logic [3*DW-1:0] pix_in,
  output logic [3*DW-1:0] pix_out
`ifdef IMG_PROC_SAT_CNT_EN
  ,
  output logic [2:0]      sat
`endif
);

  localparam logic [31:0]   MAXW = 32'((64'd1 << DW) - 1);
  localparam logic [DW-1:0] MAXC = '1;

  logic [DW-1:0] c     [3];
  logic [DW-1:0] o     [3];
  logic [31:0]   add_w [3];
  logic [31:0]   sub_w [3];
  logic [31:0]   gray_w;
  logic          unused_hi;

  // split components and form the candidate results
  always_comb begin
    for (int k = 0; k < 3; k++) begin
      c[k]     = pix_in[k*DW +: DW];
      add_w[k] = sat_add(32'(c[k]), 32'(value), MAXW);
      sub_w[k] = sat_sub(32'(c[k]), 32'(value));
    end
    gray_w = avg3(32'(c[2]), 32'(c[1]), 32'(c[0]));
  end

  // select the result for the active mode; 5-7 fall back to pass
  always_comb begin
    for (int k = 0; k < 3; k++) o[k] = c[k];
    unique case (1'b1)
      (mode == MODE_ADD):
        for (int k = 0; k < 3; k++) o[k] = add_w[k][DW-1:0];
      (mode == MODE_SUB):
        for (int k = 0; k < 3; k++) o[k] = sub_w[k][DW-1:0];
      (mode == MODE_INV):
        for (int k = 0; k < 3; k++) o[k] = MAXC - gray_w[DW-1:0];
      (mode == MODE_THRESH):
        for (int k = 0; k < 3; k++)
          o[k] = (gray_w > 32'(thresh)) ? MAXC : '0;
      default: ;
    endcase
    pix_out = {o[2], o[1], o[0]};
  end

  assign unused_hi = ^{add_w[0][31:DW], add_w[1][31:DW],
                       add_w[2][31:DW], sub_w[0][31:DW],
                       sub_w[1][31:DW], sub_w[2][31:DW]};

`ifdef IMG_PROC_SAT_CNT_EN
  // a component clips when the true result leaves 0..MAX
  always_comb begin
    for (int k = 0; k < 3; k++)
      sat[k] = ((mode == MODE_ADD) &&
                (({1'b0, c[k]} + {1'b0, value}) > {1'b0, MAXC})) ||
               ((mode == MODE_SUB) && (value > c[k]));
  end
`endif

endmodule

// File: rtl/img_stream_proc.sv
// img_stream_proc: framed RGB stream processor with runtime point op.
// IMG_PROC_SAT_CNT_EN adds sat_count (clipped components per frame).
module img_stream_proc
  import img_proc_pkg::*;
#(
  parameter int WIDTH          = 500,
  parameter int HEIGHT         = 500,
  parameter int NPIX           = 2,
  parameter int DW             = 8,
  parameter int START_UP_DELAY = 100,
  parameter int HSYNC_DELAY    = 160
) (
  input  logic                 HCLK,
  input  logic                 HRESET,
  input  logic                 start,
  input  logic [2:0]           cfg_mode,
  input  logic [DW-1:0]        cfg_value,
  input  logic [DW-1:0]        cfg_thresh,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [NPIX*3*DW-1:0] in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [NPIX*3*DW-1:0] out_data,
  output logic                 VSYNC,
  output logic                 HSYNC,
  output logic                 out_eol,
  output logic                 ctrl_done
`ifdef IMG_PROC_SAT_CNT_EN
  ,
  output logic [31:0]          sat_count
`endif
);

  localparam int CW   = $clog2(WIDTH + 1);
  localparam int RW   = $clog2(HEIGHT + 1);
  localparam int DMAX = (START_UP_DELAY > HSYNC_DELAY) ?
                        START_UP_DELAY : HSYNC_DELAY;
  localparam int DCW  = $clog2(DMAX + 1);

  localparam logic [CW-1:0]  COL_LAST = CW'(WIDTH - NPIX);
  localparam logic [RW-1:0]  ROW_LAST = RW'(HEIGHT - 1);
  localparam logic [DCW-1:0] VS_LAST  = DCW'(START_UP_DELAY - 1);
  localparam logic [DCW-1:0] HS_LAST  = DCW'(HSYNC_DELAY - 1);

  state_e                state;
  logic [CW-1:0]         col;
  logic [RW-1:0]         row;
  logic [DCW-1:0]        dcnt;
  logic [2:0]            mode_q;
  logic [DW-1:0]         value_q;
  logic [DW-1:0]         thresh_q;
  logic [NPIX*3*DW-1:0]  op_data;
  logic                  accept;
  logic                  line_end;
  logic                  drain_done;

  assign in_ready   = (state == ST_DATA) & (~out_valid | out_ready);
  assign accept     = in_valid & in_ready;
  assign line_end   = (col == COL_LAST);
  assign drain_done = (state == ST_DRAIN) & (~out_valid | out_ready);
  assign HSYNC      = out_valid;

`ifdef IMG_PROC_SAT_CNT_EN
  logic [NPIX*3-1:0] sat_all;
  logic [31:0]       sat_beat;
  logic [31:0]       sat_acc;
`endif

  for (genvar k = 0; k < NPIX; k++) begin : g_pix
    img_pix_op #(
      .DW (DW)
    ) u_op (
      .mode    (mode_q),
      .value   (value_q),
      .thresh  (thresh_q),
      .pix_in  (in_data[k*3*DW +: 3*DW]),
      .pix_out (op_data[k*3*DW +: 3*DW])
`ifdef IMG_PROC_SAT_CNT_EN
      ,
      .sat     (sat_all[k*3 +: 3])
`endif
    );
  end

  // frame sequencer, raster counters and the output register
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state     <= ST_IDLE;
      col       <= '0;
      row       <= '0;
      dcnt      <= '0;
      mode_q    <= MODE_PASS;
      value_q   <= '0;
      thresh_q  <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_eol   <= 1'b0;
      VSYNC     <= 1'b0;
      ctrl_done <= 1'b0;
    end else begin
      ctrl_done <= 1'b0;
      if (accept) begin
        out_valid <= 1'b1;
        out_data  <= op_data;
        out_eol   <= line_end;
      end else if (out_ready) begin
        out_valid <= 1'b0;
        out_eol   <= 1'b0;
      end
      unique case (state)
        ST_IDLE: begin
          if (start) begin
            state    <= ST_VSYNC;
            VSYNC    <= 1'b1;
            dcnt     <= '0;
            col      <= '0;
            row      <= '0;
            mode_q   <= cfg_mode;
            value_q  <= cfg_value;
            thresh_q <= cfg_thresh;
          end
        end
        ST_VSYNC: begin
          if (dcnt == VS_LAST) begin
            state <= ST_HSYNC;
            VSYNC <= 1'b0;
            dcnt  <= '0;
          end else begin
            dcnt <= dcnt + 1'b1;
          end
        end
        ST_HSYNC: begin
          if (dcnt == HS_LAST) begin
            state <= ST_DATA;
            dcnt  <= '0;
          end else begin
            dcnt <= dcnt + 1'b1;
          end
        end
        ST_DATA: begin
          if (accept) begin
            if (line_end) begin
              col <= '0;
              if (row == ROW_LAST) begin
                row   <= '0;
                state <= ST_DRAIN;
              end else begin
                row   <= row + 1'b1;
                state <= ST_HSYNC;
              end
            end else begin
              col <= col + CW'(NPIX);
            end
          end
        end
        ST_DRAIN: begin
          if (drain_done) begin
            state     <= ST_IDLE;
            ctrl_done <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef IMG_PROC_SAT_CNT_EN
  // number of clipped components in the accepted beat
  always_comb begin
    sat_beat = '0;
    for (int j = 0; j < NPIX*3; j++)
      sat_beat = sat_beat + 32'(sat_all[j]);
  end

  // per-frame clip tally, published when the frame completes
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      sat_acc   <= '0;
      sat_count <= '0;
    end else begin
      if ((state == ST_IDLE) && start)
        sat_acc <= '0;
      else if (accept)
        sat_acc <= sat_acc + sat_beat;
      if (drain_done)
        sat_count <= sat_acc;
    end
  end
`endif

endmodule
